// File: rtl/riscv_fetch.sv
// Instruction fetch stage: PC, request/grant fetch port, response FIFO and valid/ready head.
// Optional misaligned-redirect detection is enabled with `define RISCV_FETCH_ALIGN_CHECK_EN.
module riscv_fetch #(
   parameter int                     BUS_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0]   RESET_PC  = '0,
   parameter int                     DEPTH     = 2
) (
   input  logic                 i_CLK,
   input  logic                 i_RSTn,
   output logic                 o_IMEM_REQ,
   output logic [BUS_WIDTH-1:0] o_IMEM_ADDR,
   input  logic                 i_IMEM_GNT,
   input  logic                 i_IMEM_RVALID,
   input  logic [BUS_WIDTH-1:0] i_IMEM_RDATA,
   input  logic                 i_REDIRECT,
   input  logic [BUS_WIDTH-1:0] i_REDIRECT_PC,
   output logic [BUS_WIDTH-1:0] o_INST,
   output logic [BUS_WIDTH-1:0] o_PC,
   output logic                 o_VALID,
   input  logic                 i_READY
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
   ,
   output logic                 o_MISALIGN
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [BUS_WIDTH-1:0] NOP = BUS_WIDTH'(32'h0000_0013);

   logic [BUS_WIDTH-1:0] pc_q;
   logic                 started_q;
   logic [BUS_WIDTH-1:0] inst_mem [DEPTH];
   logic [BUS_WIDTH-1:0] pc_mem   [DEPTH];
   logic [BUS_WIDTH-1:0] rq_pc    [DEPTH];
   logic [PTR_W-1:0]     rd_ptr, wr_ptr, rq_rd, rq_wr;
   logic [CNT_W-1:0]     count, pend, drop, drop_redir;
   logic [CNT_W:0]       used;
   logic                 halt, pop, gnt_fire, rsp_keep, rsp_drop, push;
   logic [BUS_WIDTH-1:0] redir_pc;

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn)         misalign_q <= 1'b0;
      else if (i_REDIRECT) misalign_q <= |i_REDIRECT_PC[1:0];
   end

   assign halt       = misalign_q;
   assign o_MISALIGN = misalign_q;
   assign redir_pc   = i_REDIRECT_PC;
`else
   assign halt       = 1'b0;
   assign redir_pc   = i_REDIRECT_PC & ~BUS_WIDTH'(3);
`endif

   assign o_VALID     = (count != '0);
   assign o_INST      = o_VALID ? inst_mem[rd_ptr] : NOP;
   assign o_PC        = o_VALID ? pc_mem[rd_ptr]   : pc_q;
   assign o_IMEM_ADDR = pc_q;

   assign pop      = o_VALID & i_READY;
   assign gnt_fire = o_IMEM_REQ & i_IMEM_GNT;
   assign rsp_keep = i_IMEM_RVALID & (drop == '0);
   assign rsp_drop = i_IMEM_RVALID & (drop != '0);
   assign push     = rsp_keep & ~i_REDIRECT;

   // A pop this cycle frees a slot, so it counts as credit; this is what
   // sustains one instruction per cycle without ever overflowing the FIFO.
   assign used = {1'b0, count} + {1'b0, pend} - (CNT_W+1)'(pop);

   // Everything still on its way back (already-dropped or not) must be discarded.
   assign drop_redir = drop + pend + CNT_W'(gnt_fire) - CNT_W'(rsp_keep) - CNT_W'(rsp_drop);

   always_comb begin
      // NOTE: give every always_comb output a default first so no latch is inferred.
      o_IMEM_REQ = 1'b0;
      if (started_q && !halt && !i_REDIRECT && (used < (CNT_W+1)'(DEPTH)))
         o_IMEM_REQ = 1'b1;
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         // NOTE: sequential state uses non-blocking assignments only, avoiding races between flops.
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         rq_rd     <= '0;
         rq_wr     <= '0;
         count     <= '0;
         pend      <= '0;
         drop      <= '0;
      end else begin
         started_q <= 1'b1;
         if (i_REDIRECT) begin
            pc_q   <= redir_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            rq_rd  <= '0;
            rq_wr  <= '0;
            count  <= '0;
            pend   <= '0;
            drop   <= drop_redir;
         end else begin
            if (gnt_fire) begin
               pc_q  <= pc_q + BUS_WIDTH'(4);
               rq_wr <= rq_wr + PTR_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               rq_rd  <= rq_rd + PTR_W'(1);
            end
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            if (rsp_drop) drop   <= drop - CNT_W'(1);
            pend  <= pend + CNT_W'(gnt_fire) - CNT_W'(rsp_keep);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // NOTE: storage arrays are not reset; pointers and counts decide which entries are live.
   always_ff @(posedge i_CLK) begin
      if (gnt_fire) rq_pc[rq_wr] <= pc_q;
      if (push) begin
         inst_mem[wr_ptr] <= i_IMEM_RDATA;
         pc_mem[wr_ptr]   <= rq_pc[rq_rd];
      end
   end

endmodule
